// File: rtl/video_rd_sched_if.sv
// Read-request bus between the frame-read scheduler (master) and the
// frame-buffer memory arbiter (slave).
interface video_rd_sched_if #(
   parameter int ADDR_W = 24
);
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic [8:0]        rd_len;
   logic              rd_ack;
   logic              rd_done;

   modport master (output rd_req, rd_addr, rd_len, input rd_ack, rd_done);
   modport slave  (input rd_req, rd_addr, rd_len, output rd_ack, rd_done);
endinterface

// File: rtl/video_rd_sched.sv
// Frame-read scheduler: flushes the pixel FIFO at each frame start, then issues
// burst reads while the FIFO has room. Define DOUBLE_BUF_EN for double buffering.
module video_rd_sched #(
   parameter int                 H_DISP     = 800,
   parameter int                 V_DISP     = 480,
   parameter int                 BURST_LEN  = 64,
   parameter int                 FIFO_DEPTH = 1024,
   parameter int                 LVL_W      = 11,
   parameter int                 ADDR_W     = 24,
   parameter logic [ADDR_W-1:0]  BASE_ADDR0 = '0,
   parameter logic [ADDR_W-1:0]  BASE_ADDR1 = ADDR_W'(24'h060000),
   parameter int                 FLUSH_CYC  = 4
) (
   input  logic                pixel_clk,
   input  logic                sys_rst_n,
   input  logic                video_vs_i,
   input  logic                data_req_i,
   input  logic [LVL_W-1:0]    fifo_level_i,
   input  logic                buf_swap_req_i,
   video_rd_sched_if.master    rd_bus,
   output logic                fifo_flush_o,
   output logic                underflow_o,
   output logic [15:0]         frame_cnt_o,
   output logic                busy_o
);

   localparam int CMP_W = LVL_W + 1;

   typedef enum logic [2:0] {IDLE, FLUSH, CHECK, REQ, BUSY, DONE} state_t;

   state_t            state_q, state_d;
   logic              vsPrev_q;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [19:0]       wordsLeft_q, wordsLeft_d;
   logic [7:0]        flushCnt_q, flushCnt_d;
   logic              restartPend_q, restartPend_d;
   logic              underflow_q, underflow_d;
   logic [15:0]       frameCnt_q, frameCnt_d;

   logic              frameStart;
   logic              startFrame;
   logic [8:0]        lenNext;
   logic [CMP_W-1:0]  roomSum;
   logic              hasRoom;
   logic [ADDR_W-1:0] baseAddr;

   assign frameStart = vsPrev_q & ~video_vs_i;
   assign lenNext    = (wordsLeft_q < 20'(BURST_LEN)) ? wordsLeft_q[8:0] : 9'(BURST_LEN);
   assign roomSum    = CMP_W'(fifo_level_i) + CMP_W'(lenNext);
   assign hasRoom    = (roomSum <= CMP_W'(FIFO_DEPTH));

`ifdef DOUBLE_BUF_EN
   logic bufSel_q, bufSel_d;
   logic swapPend_q, swapPend_d;

   // A swap request waits for the next frame start; a request arriving in the
   // frame-start cycle itself stays pending for the following frame.
   always_comb begin
      bufSel_d   = bufSel_q ^ (startFrame & swapPend_q);
      swapPend_d = (swapPend_q & ~startFrame) | buf_swap_req_i;
      baseAddr   = bufSel_d ? BASE_ADDR1 : BASE_ADDR0;
   end

   always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         bufSel_q   <= 1'b0;
         swapPend_q <= 1'b0;
      end else begin
         bufSel_q   <= bufSel_d;
         swapPend_q <= swapPend_d;
      end
   end
`else
   logic unusedSwap;
   assign unusedSwap = buf_swap_req_i;
   assign baseAddr   = BASE_ADDR0;
`endif

   // Next-state logic; a frame start seen mid-handshake is parked in
   // restartPend and acted on once the burst has fully landed.
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      wordsLeft_d   = wordsLeft_q;
      flushCnt_d    = flushCnt_q;
      restartPend_d = restartPend_q;
      startFrame    = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (frameStart) startFrame = 1'b1;
         end
         FLUSH: begin
            if (frameStart)            startFrame = 1'b1;
            else if (flushCnt_q == '0) state_d = CHECK;
            else                       flushCnt_d = flushCnt_q - 8'd1;
         end
         CHECK: begin
            if (frameStart)              startFrame = 1'b1;
            else if (wordsLeft_q == '0)  state_d = DONE;
            else if (hasRoom)            state_d = REQ;
         end
         REQ: begin
            if (frameStart)    restartPend_d = 1'b1;
            if (rd_bus.rd_ack) state_d = BUSY;
         end
         BUSY: begin
            if (frameStart) restartPend_d = 1'b1;
            if (rd_bus.rd_done) begin
               addr_d      = addr_q + ADDR_W'(lenNext);
               wordsLeft_d = wordsLeft_q - 20'(lenNext);
               if (restartPend_q || frameStart) startFrame = 1'b1;
               else                             state_d = CHECK;
            end
         end
         default: state_d = IDLE;
      endcase

      if (startFrame) begin
         state_d       = FLUSH;
         addr_d        = baseAddr;
         wordsLeft_d   = 20'(H_DISP * V_DISP);
         flushCnt_d    = 8'(FLUSH_CYC - 1);
         restartPend_d = 1'b0;
      end
   end

   // Frame counter and sticky underflow; underflow is not judged while flushing.
   always_comb begin
      frameCnt_d  = frameCnt_q + (startFrame ? 16'd1 : 16'd0);
      underflow_d = underflow_q;
      if (startFrame)
         underflow_d = 1'b0;
      else if (data_req_i && (fifo_level_i == '0) && (state_q != FLUSH))
         underflow_d = 1'b1;
   end

   always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q       <= IDLE;
         vsPrev_q      <= 1'b1;
         addr_q        <= '0;
         wordsLeft_q   <= '0;
         flushCnt_q    <= '0;
         restartPend_q <= 1'b0;
         underflow_q   <= 1'b0;
         frameCnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         vsPrev_q      <= video_vs_i;
         addr_q        <= addr_d;
         wordsLeft_q   <= wordsLeft_d;
         flushCnt_q    <= flushCnt_d;
         restartPend_q <= restartPend_d;
         underflow_q   <= underflow_d;
         frameCnt_q    <= frameCnt_d;
      end
   end

   assign rd_bus.rd_req  = (state_q == REQ);
   assign rd_bus.rd_addr = addr_q;
   assign rd_bus.rd_len  = lenNext;
   assign fifo_flush_o   = (state_q == FLUSH);
   assign underflow_o    = underflow_q;
   assign frame_cnt_o    = frameCnt_q;
   assign busy_o         = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_video_rd_sched.sv
// Scoreboard bench for video_rd_sched with a 100-word frame (one 64-word and one
// 36-word burst) and a behavioural arbiter answering the read handshake.
module tb_video_rd_sched;

   typedef struct packed {
      logic [23:0] addr;
      logic [8:0]  len;
   } req_t;

   logic        pixelClk;
   logic        sysRstN;
   logic        videoVs;
   logic        dataReq;
   logic [10:0] fifoLevel;
   logic        bufSwapReq;
   logic        fifoFlush;
   logic        underflowO;
   logic [15:0] frameCnt;
   logic        busyO;

   int   checks   = 0;
   int   failures = 0;
   req_t sbQueue[$];

   int   ackDelay  = 0;
   int   doneDelay = 0;
   logic arbEnable = 1'b0;
   int   ackWait   = 0;
   int   doneWait  = 0;
   logic inFlight  = 1'b0;

   req_t monCur;
   logic monPrevReq;
   logic got;

   video_rd_sched_if #(.ADDR_W(24)) busIf ();

   video_rd_sched #(
      .H_DISP(100), .V_DISP(1), .BURST_LEN(64), .FIFO_DEPTH(1024),
      .LVL_W(11), .ADDR_W(24), .FLUSH_CYC(4)
   ) dut (
      .pixel_clk      (pixelClk),
      .sys_rst_n      (sysRstN),
      .video_vs_i     (videoVs),
      .data_req_i     (dataReq),
      .fifo_level_i   (fifoLevel),
      .buf_swap_req_i (bufSwapReq),
      .rd_bus         (busIf),
      .fifo_flush_o   (fifoFlush),
      .underflow_o    (underflowO),
      .frame_cnt_o    (frameCnt),
      .busy_o         (busyO)
   );

   initial begin
      pixelClk = 1'b0;
      forever #5 pixelClk = ~pixelClk;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, required finish before 500000");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic vs, input logic req, input logic [10:0] level);
      @(posedge pixelClk);
      #1;
      videoVs   = vs;
      dataReq   = req;
      fifoLevel = level;
   endtask

   task automatic pushReq(input logic [23:0] addr, input logic [8:0] len);
      req_t r;
      r.addr = addr;
      r.len  = len;
      sbQueue.push_back(r);
   endtask

   task automatic waitIdle(input int maxCycles);
      int n;
      n = 0;
      @(negedge pixelClk);
      while (busyO && n < maxCycles) begin
         @(negedge pixelClk);
         n++;
      end
      checkOutput("frame_complete_busy", 32'(busyO), 32'd0);
      checkOutput("frame_complete_req", 32'(busIf.rd_req), 32'd0);
      checkOutput("scoreboard_drained", 32'(sbQueue.size()), 32'd0);
   endtask

   task automatic runFrame();
      applyStimulus(1'b1, 1'b0, 11'd0);
      applyStimulus(1'b0, 1'b0, 11'd0);
      @(posedge pixelClk);
      waitIdle(300);
   endtask

   // Behavioural arbiter: ack after ackDelay cycles, done doneDelay cycles later.
   initial begin
      busIf.rd_ack  = 1'b0;
      busIf.rd_done = 1'b0;
      forever begin
         @(posedge pixelClk);
         #1;
         busIf.rd_ack  = 1'b0;
         busIf.rd_done = 1'b0;
         if (!sysRstN) begin
            inFlight = 1'b0;
            ackWait  = 0;
            doneWait = 0;
         end else if (inFlight) begin
            if (doneWait == doneDelay) begin
               busIf.rd_done = 1'b1;
               inFlight      = 1'b0;
            end else begin
               doneWait++;
            end
         end else if (arbEnable && busIf.rd_req) begin
            if (ackWait == ackDelay) begin
               busIf.rd_ack = 1'b1;
               inFlight     = 1'b1;
               ackWait      = 0;
               doneWait     = 0;
            end else begin
               ackWait++;
            end
         end
      end
   end

   // Monitor: each new request is popped from the scoreboard and held stable.
   initial begin
      monPrevReq = 1'b0;
      monCur     = '0;
      forever begin
         @(negedge pixelClk);
         if (sysRstN && busIf.rd_req) begin
            if (!monPrevReq) begin
               if (sbQueue.size() == 0) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL unexpected_req: got addr 0x%0h len %0d, required no request",
                           busIf.rd_addr, busIf.rd_len);
               end else begin
                  monCur = sbQueue.pop_front();
                  checkOutput("req_addr", 32'(busIf.rd_addr), 32'(monCur.addr));
                  checkOutput("req_len", 32'(busIf.rd_len), 32'(monCur.len));
               end
            end else begin
               checkOutput("req_addr_stable", 32'(busIf.rd_addr), 32'(monCur.addr));
               checkOutput("req_len_stable", 32'(busIf.rd_len), 32'(monCur.len));
            end
         end
         monPrevReq = sysRstN & busIf.rd_req;
      end
   end

   initial begin
      sysRstN    = 1'b0;
      videoVs    = 1'b0;
      dataReq    = 1'b0;
      fifoLevel  = 11'd0;
      bufSwapReq = 1'b0;

      // Reset values
      repeat (3) @(posedge pixelClk);
      @(negedge pixelClk);
      checkOutput("rst_rd_req", 32'(busIf.rd_req), 32'd0);
      checkOutput("rst_rd_addr", 32'(busIf.rd_addr), 32'd0);
      checkOutput("rst_rd_len", 32'(busIf.rd_len), 32'd0);
      checkOutput("rst_fifo_flush", 32'(fifoFlush), 32'd0);
      checkOutput("rst_underflow", 32'(underflowO), 32'd0);
      checkOutput("rst_frame_cnt", 32'(frameCnt), 32'd0);
      checkOutput("rst_busy", 32'(busyO), 32'd0);

      // Frame 1: video_vs already low, so the first clock is a frame start
      pushReq(24'd0, 9'd64);
      pushReq(24'd64, 9'd36);
      ackDelay  = 1;
      doneDelay = 10;
      arbEnable = 1'b1;
      @(posedge pixelClk);
      #1 sysRstN = 1'b1;
      @(posedge pixelClk);
      for (int i = 0; i < 4; i++) begin
         @(negedge pixelClk);
         checkOutput("flush_active", 32'(fifoFlush), 32'd1);
         checkOutput("no_req_in_flush", 32'(busIf.rd_req), 32'd0);
      end
      @(negedge pixelClk);
      checkOutput("flush_ended", 32'(fifoFlush), 32'd0);
      checkOutput("req_not_early", 32'(busIf.rd_req), 32'd0);
      @(negedge pixelClk);
      checkOutput("first_req_latency", 32'(busIf.rd_req), 32'd1);
      checkOutput("frame_cnt_1", 32'(frameCnt), 32'd1);
      waitIdle(300);

      // Frame 2: FIFO too full for a 64-word burst until level drops to 960
      pushReq(24'd0, 9'd64);
      pushReq(24'd64, 9'd36);
      ackDelay  = 0;
      doneDelay = 3;
      applyStimulus(1'b1, 1'b0, 11'd980);
      applyStimulus(1'b0, 1'b0, 11'd980);
      @(posedge pixelClk);
      @(negedge pixelClk);
      checkOutput("frame_cnt_2", 32'(frameCnt), 32'd2);
      repeat (12) @(negedge pixelClk);
      checkOutput("full_fifo_no_req", 32'(busIf.rd_req), 32'd0);
      checkOutput("full_fifo_busy", 32'(busyO), 32'd1);
      applyStimulus(1'b0, 1'b0, 11'd960);
      got = 1'b0;
      for (int i = 0; i < 2 && !got; i++) begin
         @(negedge pixelClk);
         got = busIf.rd_req;
      end
      checkOutput("room_exact_req", 32'(got), 32'd1);
      waitIdle(300);

      // Underflow: only with an empty FIFO, and sticky
      applyStimulus(1'b0, 1'b1, 11'd5);
      applyStimulus(1'b0, 1'b0, 11'd5);
      @(negedge pixelClk);
      checkOutput("uf_level_nonzero", 32'(underflowO), 32'd0);
      applyStimulus(1'b0, 1'b1, 11'd0);
      applyStimulus(1'b0, 1'b0, 11'd0);
      @(negedge pixelClk);
      checkOutput("uf_set", 32'(underflowO), 32'd1);
      repeat (5) @(negedge pixelClk);
      checkOutput("uf_sticky", 32'(underflowO), 32'd1);

      // Frame 3 restarted during FLUSH; underflow cleared, ignored while flushing
      pushReq(24'd0, 9'd64);
      pushReq(24'd64, 9'd36);
      applyStimulus(1'b1, 1'b0, 11'd0);
      applyStimulus(1'b0, 1'b0, 11'd0);
      applyStimulus(1'b0, 1'b1, 11'd0);
      applyStimulus(1'b1, 1'b0, 11'd0);
      @(negedge pixelClk);
      checkOutput("uf_cleared_flush_ignored", 32'(underflowO), 32'd0);
      checkOutput("frame_cnt_3", 32'(frameCnt), 32'd3);
      applyStimulus(1'b0, 1'b0, 11'd0);
      @(posedge pixelClk);
      for (int i = 0; i < 4; i++) begin
         @(negedge pixelClk);
         checkOutput("restart_flush_active", 32'(fifoFlush), 32'd1);
      end
      @(negedge pixelClk);
      checkOutput("restart_flush_ended", 32'(fifoFlush), 32'd0);
      checkOutput("frame_cnt_4", 32'(frameCnt), 32'd4);
      @(negedge pixelClk);
      checkOutput("restart_req_latency", 32'(busIf.rd_req), 32'd1);
      waitIdle(300);

      // Frame 5: frame start while BUSY completes the burst, then restarts
      pushReq(24'd0, 9'd64);
      pushReq(24'd0, 9'd64);
      pushReq(24'd64, 9'd36);
      ackDelay  = 0;
      doneDelay = 20;
      applyStimulus(1'b1, 1'b0, 11'd0);
      applyStimulus(1'b0, 1'b0, 11'd0);
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge pixelClk);
         got = busIf.rd_ack;
      end
      checkOutput("ack_seen", 32'(got), 32'd1);
      applyStimulus(1'b1, 1'b0, 11'd0);
      applyStimulus(1'b0, 1'b0, 11'd0);
      @(posedge pixelClk);
      for (int i = 0; i < 5; i++) begin
         @(negedge pixelClk);
         checkOutput("pend_no_req", 32'(busIf.rd_req), 32'd0);
         checkOutput("pend_no_flush", 32'(fifoFlush), 32'd0);
      end
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge pixelClk);
         got = busIf.rd_done;
      end
      checkOutput("done_seen", 32'(got), 32'd1);
      checkOutput("frame_cnt_pending", 32'(frameCnt), 32'd5);
      checkOutput("flush_before_done", 32'(fifoFlush), 32'd0);
      @(negedge pixelClk);
      checkOutput("flush_after_done", 32'(fifoFlush), 32'd1);
      checkOutput("frame_cnt_6", 32'(frameCnt), 32'd6);
      doneDelay = 2;
      waitIdle(300);

`ifdef DOUBLE_BUF_EN
      // Buffer swap: pending swap toggles base at the next frame start only
      applyStimulus(1'b0, 1'b0, 11'd0);
      bufSwapReq = 1'b1;
      applyStimulus(1'b0, 1'b0, 11'd0);
      bufSwapReq = 1'b0;
      pushReq(24'h060000, 9'd64);
      pushReq(24'h060040, 9'd36);
      runFrame();
      pushReq(24'h060000, 9'd64);
      pushReq(24'h060040, 9'd36);
      runFrame();
      applyStimulus(1'b0, 1'b0, 11'd0);
      bufSwapReq = 1'b1;
      applyStimulus(1'b0, 1'b0, 11'd0);
      bufSwapReq = 1'b0;
      pushReq(24'd0, 9'd64);
      pushReq(24'd64, 9'd36);
      runFrame();
      checkOutput("frame_cnt_dbuf", 32'(frameCnt), 32'd9);
`else
      // Swap request has no effect without double buffering
      applyStimulus(1'b0, 1'b0, 11'd0);
      bufSwapReq = 1'b1;
      applyStimulus(1'b0, 1'b0, 11'd0);
      bufSwapReq = 1'b0;
      pushReq(24'd0, 9'd64);
      pushReq(24'd64, 9'd36);
      runFrame();
      checkOutput("frame_cnt_7", 32'(frameCnt), 32'd7);
`endif

      // Reset while a request is outstanding
      arbEnable = 1'b0;
      pushReq(24'd0, 9'd64);
      applyStimulus(1'b1, 1'b0, 11'd0);
      applyStimulus(1'b0, 1'b0, 11'd0);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge pixelClk);
         got = busIf.rd_req;
      end
      checkOutput("req_before_reset", 32'(got), 32'd1);
      sysRstN = 1'b0;
      #1;
      checkOutput("midrst_rd_req", 32'(busIf.rd_req), 32'd0);
      checkOutput("midrst_rd_len", 32'(busIf.rd_len), 32'd0);
      checkOutput("midrst_frame_cnt", 32'(frameCnt), 32'd0);
      checkOutput("midrst_busy", 32'(busyO), 32'd0);
      checkOutput("midrst_flush", 32'(fifoFlush), 32'd0);
      checkOutput("midrst_underflow", 32'(underflowO), 32'd0);
      repeat (2) @(posedge pixelClk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
